// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O peripheral: synchronised inputs, output registers, hex display register
// and a multiplexed 7-segment scanner. Optional change-detect STATUS/irq under MMIO_IO_CHG_IRQ_EN.
module mmio_io_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          IN_CH     = 2,
  parameter int          IN_W      = 8,
  parameter int          OUT_CH    = 2,
  parameter int          OUT_W     = 16,
  parameter int          DIGITS    = 8,
  parameter int          SCAN_DIV  = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             addr,
  input  logic                    we,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    hit,
  input  logic [IN_CH*IN_W-1:0]   in_data,
  output logic [OUT_CH*OUT_W-1:0] out_data,
  output logic [7:0]              o_seg,
  output logic [DIGITS-1:0]       o_sel
`ifdef MMIO_IO_CHG_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // ---------------- address decode ----------------
  logic       in_win;
  logic [5:0] word;
  logic [3:0] idx;
  logic       sel_in, sel_out, sel_disp, sel_stat;
  logic       unused_addr;

  assign unused_addr = ^addr[1:0];
  assign in_win   = (addr[31:8] == BASE_ADDR[31:8]);
  assign word     = addr[7:2];
  assign idx      = addr[5:2];
  assign sel_in   = in_win && (word[5:4] == 2'b00) && (int'(idx) < IN_CH);
  assign sel_out  = in_win && (word[5:4] == 2'b01) && (int'(idx) < OUT_CH);
  assign sel_disp = in_win && (word == 6'h20);
`ifdef MMIO_IO_CHG_IRQ_EN
  assign sel_stat = in_win && (word == 6'h21);
`else
  assign sel_stat = 1'b0;
`endif
  assign hit = sel_in | sel_out | sel_disp | sel_stat;

  // ---------------- input synchroniser ----------------
  logic [IN_CH*IN_W-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_data;
      sync2_reg <= sync1_reg;
    end
  end

  // ---------------- output and display registers ----------------
  logic [OUT_W-1:0] out_reg [OUT_CH];
  logic [31:0]      disp_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < OUT_CH; i++) out_reg[i] <= '0;
      disp_reg <= '0;
    end else if (we) begin
      for (int i = 0; i < OUT_CH; i++)
        if (sel_out && int'(idx) == i) out_reg[i] <= wdata[OUT_W-1:0];
      if (sel_disp) disp_reg <= wdata;
    end
  end

  for (genvar gi = 0; gi < OUT_CH; gi++) begin : g_out
    assign out_data[gi*OUT_W +: OUT_W] = out_reg[gi];
  end

  // ---------------- optional change detect ----------------
`ifdef MMIO_IO_CHG_IRQ_EN
  logic [IN_CH*IN_W-1:0] prev_reg;
  logic [IN_CH-1:0]      status_reg, chg, clr;
  logic                  irq_reg;

  always_comb begin
    chg = '0;
    for (int i = 0; i < IN_CH; i++)
      chg[i] = |(sync2_reg[i*IN_W +: IN_W] ^ prev_reg[i*IN_W +: IN_W]);
  end

  assign clr = (we && sel_stat) ? wdata[IN_CH-1:0] : '0;

  // A new change wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_reg   <= '0;
      status_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      prev_reg   <= sync2_reg;
      status_reg <= (status_reg & ~clr) | chg;
      irq_reg    <= |status_reg;
    end
  end

  assign irq = irq_reg;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    rdata = '0;
    if (sel_in)
      for (int i = 0; i < IN_CH; i++)
        if (int'(idx) == i) rdata[IN_W-1:0] = sync2_reg[i*IN_W +: IN_W];
    if (sel_out)
      for (int i = 0; i < OUT_CH; i++)
        if (int'(idx) == i) rdata[OUT_W-1:0] = out_reg[i];
    if (sel_disp) rdata = disp_reg;
`ifdef MMIO_IO_CHG_IRQ_EN
    if (sel_stat) rdata[IN_CH-1:0] = status_reg;
`endif
  end

  // ---------------- 7-segment scanner ----------------
  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
    endcase
  endfunction

  logic [CNT_W-1:0]  cnt_reg;
  logic [DIG_W-1:0]  dig_reg, dig_next;
  logic              cnt_wrap;
  logic [DIGITS-1:0] sel_next, o_sel_reg;
  logic [7:0]        seg_next, o_seg_reg;

  assign cnt_wrap = (cnt_reg == CNT_W'(SCAN_DIV - 1));

  // Outputs are computed from the digit about to become current, so they change with dig.
  always_comb begin
    dig_next = dig_reg;
    if (cnt_wrap)
      dig_next = (dig_reg == DIG_W'(DIGITS - 1)) ? '0 : dig_reg + 1'b1;
    sel_next = '1;
    sel_next[dig_next] = 1'b0;
    seg_next = hex7(disp_reg[{dig_next, 2'b00} +: 4]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg   <= '0;
      dig_reg   <= '0;
      o_sel_reg <= ~DIGITS'(1);
      o_seg_reg <= 8'hC0;
    end else begin
      cnt_reg   <= cnt_wrap ? '0 : cnt_reg + 1'b1;
      dig_reg   <= dig_next;
      o_sel_reg <= sel_next;
      o_seg_reg <= seg_next;
    end
  end

  assign o_sel = o_sel_reg;
  assign o_seg = o_seg_reg;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl with a behavioural register/scan model.
// Covers the MMIO_IO_CHG_IRQ_EN feature when that macro is defined.
module tb_mmio_io_ctrl;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int IN_CH = 2, IN_W = 8, OUT_CH = 2, OUT_W = 16, DIGITS = 8, SCAN_DIV = 4;

  logic clk = 1'b0;
  logic reset, we, hit;
  logic [31:0] addr, wdata, rdata;
  logic [IN_CH*IN_W-1:0] in_data;
  logic [OUT_CH*OUT_W-1:0] out_data;
  logic [7:0] o_seg;
  logic [DIGITS-1:0] o_sel;
`ifdef MMIO_IO_CHG_IRQ_EN
  logic irq;
`endif

  mmio_io_ctrl #(
    .BASE_ADDR(BASE), .IN_CH(IN_CH), .IN_W(IN_W), .OUT_CH(OUT_CH),
    .OUT_W(OUT_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .hit(hit), .in_data(in_data), .out_data(out_data),
    .o_seg(o_seg), .o_sel(o_sel)
`ifdef MMIO_IO_CHG_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;                        // rising edges since the last reset edge
  logic [OUT_W-1:0] out_m [OUT_CH];
  logic [31:0] disp_m;
  logic [7:0] seg_tab [16];

  always @(posedge clk) begin
    if (!reset) n <= 0;
    else n <= n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < OUT_CH; i++) out_m[i] = '0;
    disp_m = '0;
  endtask

  function automatic logic [OUT_CH*OUT_W-1:0] exp_out();
    logic [OUT_CH*OUT_W-1:0] v;
    v = '0;
    for (int i = OUT_CH - 1; i >= 0; i--) v = (v << OUT_W) | (OUT_CH*OUT_W)'(out_m[i]);
    return v;
  endfunction

  function automatic int cur_dig();
    return (n / SCAN_DIV) % DIGITS;
  endfunction

  function automatic logic [7:0] exp_sel();
    logic [7:0] one;
    one = 8'd1;
    return ~(one << cur_dig());
  endfunction

  function automatic logic [7:0] exp_seg();
    return seg_tab[(disp_m >> (4 * cur_dig())) & 32'hF];
  endfunction

  // Expected read of a register given held (already synchronised) inputs.
  function automatic void exp_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    logic [31:0] off;
    int w;
    d = '0; h = 1'b0;
    off = a - BASE;
    if (off < 32'd256) begin
      w = int'(off >> 2);
      if (w < IN_CH) begin
        h = 1'b1; d = 32'((in_data >> (w * IN_W)) & ((1 << IN_W) - 1));
      end else if (w >= 16 && w < 16 + OUT_CH) begin
        h = 1'b1; d = 32'(out_m[w - 16]);
      end else if (w == 32) begin
        h = 1'b1; d = disp_m;
      end
    end
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
    $display("wr addr=%h data=%h reset=%b", a, d, reset);
    off = a - BASE;
    if (reset && off < 32'd256) begin
      if ((off >> 2) >= 16 && (off >> 2) < 16 + OUT_CH) out_m[(off >> 2) - 16] = d[OUT_W-1:0];
      if ((off >> 2) == 32) disp_m = d;
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    addr = a; we = 1'b0;
    #1;
    d = rdata; h = hit;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic h;
    in_data = '0; we = 1'b0; addr = '0; wdata = '0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    model_reset();
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", out_data); end
    checks++; if (o_sel !== 8'hFE) begin errors++; $display("FAIL reset_sel: got %h want fe", o_sel); end
    checks++; if (o_seg !== 8'hC0) begin errors++; $display("FAIL reset_seg: got %h want c0", o_seg); end
    rd(BASE + 32'h40, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL reset_rd40: got %h hit %b want 0 hit 1", d, h); end
`ifdef MMIO_IO_CHG_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
  endtask

  task automatic test_inputs();
    logic [31:0] d, e; logic h, eh;
    in_data = {8'h3C, 8'hA5};
    tick();
    rd(BASE, d, h);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL in_early: got %h want 0", d); end
    tick();
    rd(BASE, d, h);
    checks++; if (d !== 32'hA5 || h !== 1'b1) begin errors++; $display("FAIL in_ch0: got %h hit %b want a5", d, h); end
    rd(BASE + 32'h4, d, h);
    checks++; if (d !== 32'h3C) begin errors++; $display("FAIL in_ch1: got %h want 3c", d); end
    wr(BASE, 32'hFFFF_FFFF);
    rd(BASE, d, h);
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL in_ro: got %h want a5", d); end
    rd(BASE + 32'h8, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b0) begin errors++; $display("FAIL in_ch2: got %h hit %b want 0 hit 0", d, h); end
    for (int k = 0; k < 6; k++) begin
      in_data = (IN_CH*IN_W)'($urandom);
      tick(); tick();
      for (int c = 0; c < IN_CH; c++) begin
        rd(BASE + 32'(4 * c), d, h);
        exp_read(BASE + 32'(4 * c), e, eh);
        checks++; if (d !== e) begin errors++; $display("FAIL in_rand%0d: got %h want %h", c, d, e); end
      end
    end
  endtask

  task automatic test_out_rw();
    logic [31:0] d, a; logic h;
    wr(BASE + 32'h40, 32'hDEAD_BEEF);
    checks++; if (out_data[15:0] !== 16'hBEEF) begin errors++; $display("FAIL out0_data: got %h want beef", out_data[15:0]); end
    rd(BASE + 32'h40, d, h);
    checks++; if (d !== 32'h0000_BEEF) begin errors++; $display("FAIL out0_rd: got %h want 0000beef", d); end
    rd(BASE + 32'h48, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b0) begin errors++; $display("FAIL out2_rd: got %h hit %b want 0 hit 0", d, h); end
    wr(BASE + 32'h48, 32'h1234_5678);
    checks++; if (out_data !== exp_out()) begin errors++; $display("FAIL out2_wr: got %h want %h", out_data, exp_out()); end
    for (int k = 0; k < 8; k++) begin
      a = BASE + 32'h40 + 32'(4 * $urandom_range(0, OUT_CH - 1));
      wr(a, $urandom);
      checks++; if (out_data !== exp_out()) begin errors++; $display("FAIL out_rand: got %h want %h", out_data, exp_out()); end
      rd(a, d, h);
      checks++; if (d !== 32'(out_m[(a - BASE - 32'h40) >> 2])) begin errors++; $display("FAIL out_rand_rd: got %h want %h", d, out_m[(a - BASE - 32'h40) >> 2]); end
    end
  endtask

  task automatic test_decode();
    logic [31:0] d, e, a; logic h, eh;
    for (int k = 0; k < 24; k++) begin
      a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
`ifdef MMIO_IO_CHG_IRQ_EN
      if (((a - BASE) >> 2) == 33) a = BASE + 32'h80;
`endif
      rd(a, d, h);
      exp_read(a, e, eh);
      checks++; if (d !== e || h !== eh) begin errors++; $display("FAIL decode @%h: got %h hit %b want %h hit %b", a, d, h, e, eh); end
    end
`ifndef MMIO_IO_CHG_IRQ_EN
    rd(BASE + 32'h84, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b0) begin errors++; $display("FAIL stat_unmapped: got %h hit %b want 0 hit 0", d, h); end
`endif
    rd(BASE + 32'h140, d, h);
    checks++; if (h !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL out_of_window: got %h hit %b want 0 hit 0", d, h); end
  endtask

  task automatic run_scan(input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      tick();
      checks++; if (o_sel !== exp_sel()) begin errors++; $display("FAIL %s_sel n=%0d: got %h want %h", tag, n, o_sel, exp_sel()); end
      checks++; if (o_seg !== exp_seg()) begin errors++; $display("FAIL %s_seg n=%0d: got %h want %h", tag, n, o_seg, exp_seg()); end
    end
  endtask

  task automatic test_scan();
    logic [31:0] d; logic h;
    wr(BASE + 32'h80, 32'h7654_3210);
    rd(BASE + 32'h80, d, h);
    checks++; if (d !== 32'h7654_3210) begin errors++; $display("FAIL disp_rd: got %h want 76543210", d); end
    run_scan(2 * DIGITS * SCAN_DIV + 3, "scan");
    wr(BASE + 32'h80, $urandom);
    run_scan(DIGITS * SCAN_DIV + 2, "scan_rand");
  endtask

  task automatic test_back_to_back_reset();
    logic [31:0] d; logic h;
    wr(BASE + 32'h40, 32'h0000_1234);
    addr = BASE + 32'h40; wdata = 32'h0000_ABCD; we = 1'b1; reset = 1'b0;
    tick();
    we = 1'b0; reset = 1'b1;
    model_reset();
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_vs_wr: got %h want 0", out_data); end
    rd(BASE + 32'h40, d, h);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_vs_wr_rd: got %h want 0", d); end
    wr(BASE + 32'h80, 32'h89AB_CDEF);
    run_scan(2 * SCAN_DIV + 1, "prerst");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    checks++; if (o_sel !== 8'hFE || o_seg !== 8'hC0) begin errors++; $display("FAIL midscan_rst: got sel %h seg %h want fe c0", o_sel, o_seg); end
    wr(BASE + 32'h80, 32'hFEDC_BA98);
    run_scan(3 * SCAN_DIV, "postrst");
  endtask

`ifdef MMIO_IO_CHG_IRQ_EN
  task automatic test_chg_irq();
    logic [31:0] d; logic h;
    in_data = 16'h0011;
    repeat (5) tick();
    wr(BASE + 32'h84, 32'h0000_FFFF);
    tick();
    rd(BASE + 32'h84, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL stat_clear0: got %h hit %b irq %b want 0 1 0", d, h, irq); end
    in_data[15:8] = ~in_data[15:8];
    repeat (3) tick();
    rd(BASE + 32'h84, d, h);
    checks++; if (d !== 32'h2 || irq !== 1'b0) begin errors++; $display("FAIL stat_set: got %h irq %b want 2 0", d, irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
    in_data[15:8] = ~in_data[15:8];
    repeat (2) tick();
    wr(BASE + 32'h84, 32'h2);
    rd(BASE + 32'h84, d, h);
    checks++; if (d !== 32'h2 || irq !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %h irq %b want 2 1", d, irq); end
    wr(BASE + 32'h84, 32'h2);
    rd(BASE + 32'h84, d, h);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c: got %h want 0", d); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irq); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    reset = 1'b0; we = 1'b0; addr = '0; wdata = '0; in_data = '0;
    model_reset();
    test_reset();
    test_inputs();
    test_out_rw();
    test_decode();
    test_scan();
    test_back_to_back_reset();
`ifdef MMIO_IO_CHG_IRQ_EN
    test_chg_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
